// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle of the BCD timer: run controls in, count and display scan out.
interface bcd_timer_ctrl_if;
   logic        start;
   logic        stop;
   logic        clear;
   logic [15:0] count;
   logic        running;
   logic        ovf;
   logic [3:0]  an;
   logic [3:0]  seg_bcd;

   modport master (
      output start, stop, clear,
      input  count, running, ovf, an, seg_bcd
   );

   modport slave (
      input  start, stop, clear,
      output count, running, ovf, an, seg_bcd
   );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD up-counter with start/stop/clear control and a multiplexed digit scan.
module bcd_timer_ctrl #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned SCAN_DIV = 50000
) (
   input logic             clk,
   input logic             rst,
   bcd_timer_ctrl_if.slave bus
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SCAN_DIV);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [15:0]   count_q;
   logic [15:0]   count_inc;
   logic          carry;
   logic          tick;
   logic          scan_wrap;
   logic          running_q;
   logic          ovf_q;
   logic [3:0]    an_q;
   logic [3:0]    seg_c;

   assign tick      = (state == RUN) && (tick_cnt == TW'(TICK_DIV - 1));
   assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Priority clear > stop > start; stop never leaves IDLE, start never re-enters RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.stop && bus.start) state_nxt = RUN;
         RUN:     if (bus.stop)               state_nxt = PAUSE;
         PAUSE:   if (!bus.stop && bus.start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (bus.clear) state_nxt = IDLE;
   end

   // Ripple BCD increment; a digit of 9 (or an impossible 10..15) rolls to 0 and carries.
   always_comb begin
      count_inc = count_q;
      carry     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (count_q[4*i +: 4] >= 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Prescaler freezes on a non-tick stop so a later resume keeps the partial period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (bus.clear || tick) begin
         tick_cnt <= '0;
      end else if ((state == RUN) && !bus.stop) begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         if (bus.clear)  count_q <= '0;
         else if (tick)  count_q <= count_inc;
         ovf_q     <= tick && !bus.clear && (count_q == 16'h9999);
         running_q <= (state_nxt == RUN);
      end
   end

   // Free-running digit scan, independent of the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
         an_q     <= 4'b0001;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
         an_q     <= {an_q[2:0], an_q[3]};
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   always_comb begin
      seg_c = count_q[3:0];
      case (idx)
         2'd0:    seg_c = count_q[3:0];
         2'd1:    seg_c = count_q[7:4];
         2'd2:    seg_c = count_q[11:8];
         default: seg_c = count_q[15:12];
      endcase
   end

   assign bus.count   = count_q;
   assign bus.running = running_q;
   assign bus.ovf     = ovf_q;
   assign bus.an      = an_q;
   assign bus.seg_bcd = seg_c;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_timer_ctrl;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned SCAN_DIV = 2;

   typedef struct {
      logic        start;
      logic        stop;
      logic        clear;
      logic [15:0] cnt;
      logic        run;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sc;
   vec_t tbl[$];

   bcd_timer_ctrl_if bif ();

   bcd_timer_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the expected digit index is (sc / SCAN_DIV) % 4.
   always @(posedge clk or posedge rst) begin
      if (rst) sc <= 0;
      else     sc <= sc + 1;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic p, input logic c);
      bif.start = s;
      bif.stop  = p;
      bif.clear = c;
   endtask

   task automatic add(input int n, input logic s, input logic p, input logic c,
                      input logic [15:0] cnt, input logic run);
      vec_t v;
      v.start = s; v.stop = p; v.clear = c; v.cnt = cnt; v.run = run; v.ovf = 1'b0;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic chk_scan(input logic [15:0] cnt);
      int          k;
      logic [3:0]  e_an;
      logic [15:0] c;
      k    = (sc / int'(SCAN_DIV)) % 4;
      e_an = 4'b0001 << k;
      c    = cnt;
      chk("an", 16'(bif.an), 16'(e_an));
      chk("seg_bcd", 16'(bif.seg_bcd), 16'(c[4*k +: 4]));
   endtask

   initial begin
      logic ovf_seen;
      logic bad_digit;
      logic track_err;
      ovf_seen = 1'b0; bad_digit = 1'b0; track_err = 1'b0;
      drive(1'b0, 1'b0, 1'b0);

      // Table: start/run/stop/resume/clear/priority behaviour from reset.
      add(1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1);
      add(1, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1);
      add(1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0);
      add(1, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1);
      add(1, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0);
      add(1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1);
      add(1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      add(1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      add(1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
      add(1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      add(1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
      add(1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      add(1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      add(1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      add(1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Reset values while rst is held.
      #12;
      chk("rst_count", bif.count, 16'h0000);
      chk("rst_running", 16'(bif.running), 16'h0);
      chk("rst_ovf", 16'(bif.ovf), 16'h0);
      chk("rst_an", 16'(bif.an), 16'h1);
      chk("rst_seg", 16'(bif.seg_bcd), 16'h0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].start, tbl[i].stop, tbl[i].clear);
         step();
         chk($sformatf("vec%0d_count", i), bif.count, tbl[i].cnt);
         chk($sformatf("vec%0d_running", i), 16'(bif.running), 16'(tbl[i].run));
         chk($sformatf("vec%0d_ovf", i), 16'(bif.ovf), 16'(tbl[i].ovf));
      end

      // Pause with prescaler at 2, hold 10 cycles, resume: next increment 2 cycles later.
      drive(1'b1, 1'b0, 1'b0); step();
      drive(1'b0, 1'b0, 1'b0);
      repeat (4) step();
      chk("p38_pre_count", bif.count, 16'h0001);
      repeat (2) step();
      drive(1'b0, 1'b1, 1'b0); step();
      chk("p38_stop_running", 16'(bif.running), 16'h0);
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("p38_hold_count", bif.count, 16'h0001);
         chk("p38_hold_running", 16'(bif.running), 16'h0);
      end
      drive(1'b1, 1'b0, 1'b0); step();
      chk("p38_resume_running", 16'(bif.running), 16'h1);
      drive(1'b0, 1'b0, 1'b0); step();
      chk("p38_resume1_count", bif.count, 16'h0001);
      step();
      chk("p38_resume2_count", bif.count, 16'h0002);

      // Long run: 0999->1000, pause at 1234 for scan, then on to the 9999 wrap.
      drive(1'b0, 1'b0, 1'b1); step();
      drive(1'b1, 1'b0, 1'b0); step();
      for (int i = 1; i <= 4 * 1234; i++) begin
         drive(1'b0, i == 4 * 1234, 1'b0);
         step();
         if (bif.ovf) ovf_seen = 1'b1;
         for (int k = 0; k < 4; k++) if (bif.count[4*k +: 4] > 4'd9) bad_digit = 1'b1;
         if (bif.count !== to_bcd(i / 4)) track_err = 1'b1;
         if (i == 4 * 999) chk("cnt_0999", bif.count, 16'h0999);
         if (i == 4 * 1000) begin
            chk("cnt_1000", bif.count, 16'h1000);
            chk("ovf_1000", 16'(bif.ovf), 16'h0);
         end
      end
      chk("pause1234_count", bif.count, 16'h1234);
      chk("pause1234_running", 16'(bif.running), 16'h0);
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_scan(16'h1234);
      end
      drive(1'b1, 1'b0, 1'b0); step();
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4 * 8766; i++) begin
         step();
         if (i < 4 * 8766) begin
            if (bif.ovf) ovf_seen = 1'b1;
            for (int k = 0; k < 4; k++) if (bif.count[4*k +: 4] > 4'd9) bad_digit = 1'b1;
            if (bif.count !== to_bcd(1234 + i / 4)) track_err = 1'b1;
         end
      end
      chk("wrap_count", bif.count, 16'h0000);
      chk("wrap_ovf", 16'(bif.ovf), 16'h1);
      chk("wrap_running", 16'(bif.running), 16'h1);
      step();
      chk("wrap_ovf_drop", 16'(bif.ovf), 16'h0);
      chk("wrap_running_hold", 16'(bif.running), 16'h1);
      chk("wrap_count_hold", bif.count, 16'h0000);
      chk("no_early_ovf", 16'(ovf_seen), 16'h0);
      chk("digit_range", 16'(bad_digit), 16'h0);
      chk("count_track", 16'(track_err), 16'h0);

      // Asynchronous reset mid-RUN, checked before the next clock edge.
      repeat (3) step();
      chk("prerst_count", bif.count, 16'h0001);
      #3 rst = 1'b1;
      #1;
      chk("arst_count", bif.count, 16'h0000);
      chk("arst_running", 16'(bif.running), 16'h0);
      chk("arst_ovf", 16'(bif.ovf), 16'h0);
      chk("arst_an", 16'(bif.an), 16'h1);
      chk("arst_seg", 16'(bif.seg_bcd), 16'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("postrst_running", 16'(bif.running), 16'h0);
         chk("postrst_count", bif.count, 16'h0000);
      end
      chk_scan(16'h0000);
      drive(1'b1, 1'b0, 1'b0); step();
      chk("postrst_start", 16'(bif.running), 16'h1);
      drive(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per count increment; legal range is >= 2.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per display digit slot; legal range is >= 2.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  synchronous level sampled each cycle; requests counting.
REQ-007 stop  input  1  synchronous level sampled each cycle; requests pause.
REQ-008 clear  input  1  synchronous level sampled each cycle; returns block to idle with zero count.
REQ-009 count  output  16  packed BCD count: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-010 running  output  1  high while in state RUN.
REQ-011 ovf  output  1  single-cycle pulse on 9999->0000 wrap.
REQ-012 an  output  4  one-hot digit select; bit i selects count digit i.
REQ-013 seg_bcd  output  4  BCD value of the digit selected by an.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, PAUSE.
REQ-015 Input priority SHALL be clear > stop > start in every state.
REQ-016 In any state, clear SHALL move the FSM to IDLE, set count to 0x0000 and set the tick prescaler to 0 on the next edge.
REQ-017 In IDLE, start (without clear) SHALL move the FSM to RUN; the prescaler begins counting from 0.
REQ-018 In RUN, stop (without clear) SHALL move the FSM to PAUSE, holding both the count and the prescaler value.
REQ-019 In PAUSE, start (without clear or stop) SHALL move the FSM to RUN and resume the prescaler from its held value.
REQ-020 In IDLE, stop SHALL be ignored; in RUN, start SHALL be ignored.
REQ-021 In RUN, the prescaler SHALL count 0..TICK_DIV-1; the cycle in which it equals TICK_DIV-1 is a tick, and the prescaler returns to 0.
REQ-022 On a tick, count SHALL increment in BCD: digit i increments if all lower digits equal 9, and any digit at 9 that is carried out of becomes 0.
REQ-023 No count digit SHALL ever hold a value from 10 to 15.
REQ-024 On a tick with count = 0x9999, count SHALL become 0x0000, ovf SHALL be high for exactly that one following cycle, and the FSM SHALL stay in RUN.
REQ-025 A tick coinciding with stop SHALL still apply the increment; the FSM enters PAUSE with the prescaler at 0.
REQ-026 A tick coinciding with clear SHALL be discarded: count becomes 0x0000 and ovf stays low.
REQ-027 Latency: start sampled at edge N gives running=1 after edge N; the first increment is visible after edge N+TICK_DIV.
REQ-028 The scan prescaler SHALL run freely in every FSM state, counting 0..SCAN_DIV-1.
REQ-029 On each scan-prescaler wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-030 an SHALL equal the one-hot encoding of the digit index.
REQ-031 seg_bcd SHALL be a combinational selection of the indexed count nibble, updating in the same cycle as count or the index.
REQ-032 running and ovf SHALL be registered outputs.

Reset
REQ-033 Asserting rst SHALL immediately (asynchronously) force: FSM=IDLE, count=0x0000, tick prescaler=0, scan prescaler=0, digit index=0, an=4'b0001, seg_bcd=0, running=0, ovf=0.
REQ-034 Asserting rst in the middle of RUN or PAUSE SHALL discard all progress; after release the block waits in IDLE for start.
REQ-035 Deasserting rst SHALL cause no state change until the first rising clk edge.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-036 Reset, then one-cycle start pulse -> running=1 next cycle; count=0x0001 after 4 cycles and 0x0003 after 12 cycles.
REQ-037 Preload to 0x0999 via run, then one tick -> count=0x1000, ovf stays 0; at 0x9999 one tick -> count=0x0000, ovf high for 1 cycle, running stays 1.
REQ-038 RUN with prescaler=2, stop for 1 cycle, wait 10 cycles, then start -> count unchanged during PAUSE; next increment occurs 2 cycles after resume.
REQ-039 start+stop+clear together in RUN -> IDLE, count=0x0000, running=0; stop alone in IDLE -> no change.
REQ-040 count=0x1234 held in PAUSE -> an cycles 0001,0010,0100,1000 every 2 cycles, with seg_bcd 4,3,2,1 respectively.
REQ-041 rst pulse mid-RUN, asynchronous to clk -> all outputs at reset values before the next edge; FSM stays in IDLE until start.
